glyph_text_renderer: RTL
========================

# glyph_text_renderer

Text-mode pixel stage that sits directly downstream of the VGA sync generator. It consumes the generator's `hpos`, `vpos`, `display_on`, `hsync` and `vsync`, looks up the character cell under the beam in an internal text buffer, fetches the glyph row from an external synchronous glyph ROM, and emits RGB222 pixels. The sync and blanking signals are delayed to stay cycle-aligned with the pixel. A host-side write port fills the text buffer.

## Interface
- `COLS`, 32: character columns in the grid.
- `ROWS`, 24: character rows in the grid.
- `SCALE_LOG2`, 2: glyph pixel scale, 2^SCALE_LOG2 screen pixels per glyph pixel. A cell is 8·2^S pixels square.
- `ADDR_W`, 10: text buffer address width. Requires 2^ADDR_W ≥ COLS·ROWS.
- `clk` input 1: pixel clock, the same clock as the sync generator.
- `rst_n` input 1: reset, synchronous, active-low.
- `hpos` input 11: horizontal beam position from the sync generator.
- `vpos` input 10: vertical beam position.
- `display_on` input 1: active-video flag.
- `hsync_in`, `vsync_in` input 1 each: syncs from the generator, already at panel polarity.
- `wr_en` input 1: text buffer write strobe.
- `wr_addr` input ADDR_W: cell index, row·COLS + col.
- `wr_data` input 16: cell word. [6:0] char code, [7] blink, [10:8] fg RGB111, [13:11] bg RGB111, [15:14] reserved (stored, ignored).
- `rom_addr` output 10: glyph ROM address, {char[6:0], glyph_row[2:0]}.
- `rom_data` input 8: glyph row. Valid exactly one cycle after `rom_addr`. Bit 7 is the leftmost pixel.
- `rgb` output 6: {R1,R0,G1,G0,B1,B0}. Each RGB111 bit is replicated to 2 bits.
- `hsync_out`, `vsync_out`, `display_on_out` output 1 each: delayed copies aligned with `rgb`.

## Operation
- Stage 0 (edge E0):
  - col = hpos >> (3+S), row = vpos >> (3+S).
  - in_grid = display_on && col < COLS && row < ROWS.
  - Issue a synchronous text RAM read at row·COLS+col. The address is forced to 0 when not in_grid.
  - Register glyph_row = (vpos>>S)&7, bit_col = (hpos>>S)&7, in_grid, and the sync/blank inputs.
- Stage 1 (E1): RAM word available. Register `rom_addr`, fg, bg, blink, bit_col, in_grid, and syncs.
- Stage 2 (E2): `rom_data` valid. pix = rom_data[7−bit_col] & ~(blink & blink_phase). Register pix, fg, bg, in_grid, and syncs.
- Stage 3 (E3): register the outputs.
  - `rgb` = expand(pix ? fg : bg) when in_grid.
  - `rgb` = 6'h00 when display_on is high but the beam is outside the grid.
  - `rgb` = 6'h00 when display_on is low.
- Text RAM holds COLS·ROWS 16-bit words with one write port and one read port.
  - A write with `wr_addr` ≥ COLS·ROWS is ignored.
  - Read and write to the same address in the same cycle returns the old word (read-before-write).
  - RAM contents are not cleared by reset.
- Blink timer:
  - 6-bit frame_cnt increments on the cycle where hpos==0 && vpos==0 is sampled, wrapping 63→0.
  - blink_phase = frame_cnt[5], so blinking glyphs are hidden for 32 frames and shown for 32 frames.
- Reset (`rst_n` low at an edge):
  - `rgb` = 0, `hsync_out` = 1, `vsync_out` = 1, `display_on_out` = 0, `rom_addr` = 0.
  - All pipeline registers are cleared: in_grid = 0, syncs = 1.
  - frame_cnt = 0.
  - Writes are ignored while `rst_n` is low.
- Reset mid-frame: the pipeline restarts cleanly. The first valid pixel appears 4 cycles after `rst_n` rises. No partial state survives.

## Timing
- Inputs sampled at edge n produce `rgb`, `hsync_out`, `vsync_out` and `display_on_out` at edge n+3. These are valid in cycle n+4, giving 4-cycle total latency.
- All sync and blank outputs carry identical latency. There is no skew between `rgb` and the syncs.
- Glyph ROM contract: `rom_addr` is registered at E1 and the ROM returns data by E2. Exactly one cycle of ROM latency; no handshake.
- A buffer write at edge w is visible to a read issued at edge w+1 or later.
- One pixel per clock. No stalls or back-pressure.

## Test plan
- Reset hold: `rst_n` low for 5 cycles with random inputs -> `rgb`=0, `hsync_out`=`vsync_out`=1, `display_on_out`=0 throughout, and for the first 4 cycles after release.
- Latency/alignment: toggle `hsync_in` at cycle 100 -> `hsync_out` toggles at cycle 104. `display_on` low -> `rgb`=0 with the same 4-cycle delay.
- Glyph render: write cell 0 = 16'h3841 ('A', fg=3'b000 blue? no: fg=0, bg=3'b111); ROM row 0 = 8'h81, S=2, beam at vpos=0 -> pixels 0–3 and 28–31 give `rgb`=6'h00, pixels 4–27 give 6'h3F, with `rom_addr`=10'h208.
- Grid edge: COLS=32, S=2, display_on high at hpos=1024+ -> out of grid, `rgb`=0. Write to `wr_addr`=768 -> no RAM change (read cell 0 unchanged).
- Blink: cell with bit7=1 and fg=3'b100 -> glyph visible in frames 0–31, `rgb`=bg only in frames 32–63, visible again at frame 64.
- Same-cycle read/write: write cell 5 while the beam reads cell 5 -> that pixel uses the old word; the next cell-5 read uses the new word.

Source files
------------

// File: rtl/glyph_text_renderer.sv
// Text-mode pixel stage: maps the beam position to a character cell, fetches the glyph row
// from an external ROM and emits RGB222 with syncs delayed to match (4-cycle latency).
module glyph_text_renderer #(
  parameter int COLS       = 32,
  parameter int ROWS       = 24,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [9:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic [5:0]        rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              display_on_out
);

  localparam int CELLS = COLS * ROWS;
  localparam int SH    = 3 + SCALE_LOG2;

  function automatic logic [5:0] expand_rgb(input logic [2:0] c);
    return {c[2], c[2], c[1], c[1], c[0], c[0]};
  endfunction

  logic [10:0]       col_d;
  logic [9:0]        row_d;
  logic              in_grid_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              pix_d;
  logic [5:0]        rgb_d;

  logic [15:0] mem_q [CELLS];
  logic [13:0] rd_word_q;
  logic [5:0]  frame_cnt_q;

  logic [2:0] glyph_row_p0_q, bit_col_p0_q;
  logic       in_grid_p0_q, hs_p0_q, vs_p0_q, de_p0_q;
  logic [9:0] rom_addr_q;
  logic [2:0] fg_p1_q, bg_p1_q, bit_col_p1_q;
  logic       blink_p1_q, in_grid_p1_q, hs_p1_q, vs_p1_q, de_p1_q;
  logic [2:0] fg_p2_q, bg_p2_q;
  logic       pix_p2_q, in_grid_p2_q, hs_p2_q, vs_p2_q, de_p2_q;
  logic [5:0] rgb_q;
  logic       hs_q, vs_q, de_q;

  // Stage 0: cell lookup; off-grid reads go to cell 0 so the RAM index stays in range
  always_comb begin
    col_d     = hpos >> SH;
    row_d     = vpos >> SH;
    in_grid_d = display_on && (32'(col_d) < COLS) && (32'(row_d) < ROWS);
    rd_addr_d = in_grid_d ? ADDR_W'(32'(row_d) * COLS + 32'(col_d)) : '0;
  end

  // Text RAM: read-before-write, not cleared by reset, writes blocked during reset
  always_ff @(posedge clk) begin
    rd_word_q <= mem_q[rd_addr_d][13:0];
    if (rst_n && wr_en && (32'(wr_addr) < CELLS)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (hpos == 11'd0 && vpos == 10'd0) begin
      frame_cnt_q <= frame_cnt_q + 6'd1;
    end
  end

  // Stage 2 pixel select and stage 3 colour expansion
  always_comb begin
    pix_d = rom_data[3'd7 - bit_col_p1_q] & ~(blink_p1_q & frame_cnt_q[5]);
    rgb_d = in_grid_p2_q ? expand_rgb(pix_p2_q ? fg_p2_q : bg_p2_q) : 6'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glyph_row_p0_q <= '0;
      bit_col_p0_q   <= '0;
      in_grid_p0_q   <= 1'b0;
      hs_p0_q        <= 1'b1;
      vs_p0_q        <= 1'b1;
      de_p0_q        <= 1'b0;
      rom_addr_q     <= '0;
      fg_p1_q        <= '0;
      bg_p1_q        <= '0;
      bit_col_p1_q   <= '0;
      blink_p1_q     <= 1'b0;
      in_grid_p1_q   <= 1'b0;
      hs_p1_q        <= 1'b1;
      vs_p1_q        <= 1'b1;
      de_p1_q        <= 1'b0;
      pix_p2_q       <= 1'b0;
      fg_p2_q        <= '0;
      bg_p2_q        <= '0;
      in_grid_p2_q   <= 1'b0;
      hs_p2_q        <= 1'b1;
      vs_p2_q        <= 1'b1;
      de_p2_q        <= 1'b0;
      rgb_q          <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      de_q           <= 1'b0;
    end else begin
      // E0: beam position decode
      glyph_row_p0_q <= vpos[SCALE_LOG2 +: 3];
      bit_col_p0_q   <= hpos[SCALE_LOG2 +: 3];
      in_grid_p0_q   <= in_grid_d;
      hs_p0_q        <= hsync_in;
      vs_p0_q        <= vsync_in;
      de_p0_q        <= display_on;
      // E1: cell word available, issue glyph ROM address
      rom_addr_q     <= {rd_word_q[6:0], glyph_row_p0_q};
      fg_p1_q        <= rd_word_q[10:8];
      bg_p1_q        <= rd_word_q[13:11];
      blink_p1_q     <= rd_word_q[7];
      bit_col_p1_q   <= bit_col_p0_q;
      in_grid_p1_q   <= in_grid_p0_q;
      hs_p1_q        <= hs_p0_q;
      vs_p1_q        <= vs_p0_q;
      de_p1_q        <= de_p0_q;
      // E2: glyph row valid
      pix_p2_q       <= pix_d;
      fg_p2_q        <= fg_p1_q;
      bg_p2_q        <= bg_p1_q;
      in_grid_p2_q   <= in_grid_p1_q;
      hs_p2_q        <= hs_p1_q;
      vs_p2_q        <= vs_p1_q;
      de_p2_q        <= de_p1_q;
      // E3: output registers
      rgb_q          <= rgb_d;
      hs_q           <= hs_p2_q;
      vs_q           <= vs_p2_q;
      de_q           <= de_p2_q;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign rgb            = rgb_q;
  assign hsync_out      = hs_q;
  assign vsync_out      = vs_q;
  assign display_on_out = de_q;

endmodule
